// File: rtl/camera_capture_param.sv
// Camera frame capture: assembles byte pairs into pixels (RGB444/RGB565/Y8), with optional
// 2x decimation, dense write addressing, frame skipping after enable and bounds checking.
module camera_capture_param #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ADDR_W      = 19,
    parameter int PIX_W       = 16,
    parameter int SKIP_FRAMES = 2
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              enable,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    input  logic [1:0]        fmt,
    input  logic              decim,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_we,
    output logic              frame_done,
    output logic              frame_ok,
    output logic              overflow
);
    localparam int CW = $clog2(H_ACTIVE + 1) + 1;
    localparam int LW = $clog2(V_ACTIVE + 1) + 1;
    localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [CW-1:0]     H_LIM     = CW'(H_ACTIVE);
    localparam logic [LW-1:0]     V_LIM     = LW'(V_ACTIVE);
    localparam logic [SW-1:0]     SKIP_N    = SW'(SKIP_FRAMES);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE_OFF, SKIP, WAIT, CAPTURE} state_t;

    state_t            state, state_nxt;
    logic              vs_s1, vs_s2, href_s1, href_s2;
    logic [7:0]        data_s1;
    logic              vs_fall, vs_rise, href_fall;
    logic [SW-1:0]     skip_cnt;
    logic              cap_act, frame_start, frame_end;
    logic              phase;
    logic [7:0]        byte0;
    logic [CW-1:0]     col;
    logic [LW-1:0]     line, line_inc, line_end;
    logic [ADDR_W-1:0] addr_cnt;
    logic [1:0]        fmt_q;
    logic              decim_q;
    logic              col_ok, line_ok, keep, pix_step, wr_fire, ovf_set;
    logic [PIX_W-1:0]  pix_asm;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            href_s1 <= 1'b0;
            href_s2 <= 1'b0;
            data_s1 <= '0;
        end else begin
            vs_s1   <= vsync;
            vs_s2   <= vs_s1;
            href_s1 <= href;
            href_s2 <= href_s1;
            data_s1 <= data;
        end
    end

    assign vs_fall   = vs_s2 & ~vs_s1;
    assign vs_rise   = ~vs_s2 & vs_s1;
    assign href_fall = href_s2 & ~href_s1;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            skip_cnt <= '0;
        end else if (state != SKIP) begin
            skip_cnt <= '0;
        end else if (vs_fall && skip_cnt != SKIP_N) begin
            skip_cnt <= skip_cnt + 1'b1;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state <= IDLE_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE_OFF;
        end else begin
            case (state)
                IDLE_OFF: state_nxt = SKIP;
                SKIP:     if (skip_cnt == SKIP_N) state_nxt = WAIT;
                WAIT:     if (vs_fall) state_nxt = CAPTURE;
                CAPTURE:  if (vs_rise) state_nxt = WAIT;
                default:  state_nxt = IDLE_OFF;
            endcase
        end
    end

    // A vs_fall inside CAPTURE is a missed frame end: restart without frame_done.
    always_comb begin
        cap_act     = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        if (enable) begin
            case (state)
                WAIT: frame_start = vs_fall;
                CAPTURE: begin
                    cap_act     = ~vs_fall;
                    frame_start = vs_fall;
                    frame_end   = vs_rise;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        col_ok   = col < H_LIM;
        line_ok  = line < V_LIM;
        keep     = ~decim_q | (~col[0] & ~line[0]);
        pix_step = cap_act & href_s1 & phase;
        wr_fire  = pix_step & col_ok & line_ok & keep;
        ovf_set  = cap_act & href_s1 & (~line_ok | (phase & ~col_ok));
        line_inc = (line == '1) ? line : line + 1'b1;
        line_end = (cap_act & href_fall) ? line_inc : line;
        pix_asm  = '0;
        case (fmt_q)
            2'd1:    pix_asm[15:0] = {byte0, data_s1};
            2'd2:    pix_asm[7:0]  = byte0;
            default: pix_asm[11:0] = {byte0[3:0], data_s1};
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pix_addr   <= '0;
            pix_data   <= '0;
            pix_we     <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            overflow   <= 1'b0;
            addr_cnt   <= '0;
            col        <= '0;
            line       <= '0;
            phase      <= 1'b0;
            byte0      <= '0;
            fmt_q      <= '0;
            decim_q    <= 1'b0;
        end else begin
            pix_we     <= wr_fire;
            frame_done <= frame_end;
            if (frame_end) begin
                frame_ok <= (line_end == V_LIM) & ~(overflow | ovf_set);
            end
            if (wr_fire) begin
                pix_addr <= addr_cnt;
                pix_data <= pix_asm;
                addr_cnt <= (addr_cnt == ADDR_LAST) ? addr_cnt : addr_cnt + 1'b1;
            end
            if (frame_start) begin
                fmt_q    <= fmt;
                decim_q  <= decim;
                addr_cnt <= '0;
                col      <= '0;
                line     <= '0;
                phase    <= 1'b0;
                overflow <= 1'b0;
            end else if (cap_act) begin
                if (ovf_set) overflow <= 1'b1;
                if (href_s1) begin
                    if (!phase) begin
                        byte0 <= data_s1;
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        col   <= (col == '1) ? col : col + 1'b1;
                    end
                end else if (href_fall) begin
                    // A dangling odd byte is dropped here.
                    phase <= 1'b0;
                    line  <= line_inc;
                    col   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_capture_param.sv
// Directed bench for camera_capture_param on a small 8x4 sensor geometry.
module tb_camera_capture_param;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 5;
    localparam int PW = 16;
    localparam int SK = 2;
    localparam int EW = AW + PW;

    logic          pclk = 1'b0;
    logic          rst, enable, vsync, href, decim;
    logic [7:0]    data;
    logic [1:0]    fmt;
    logic [AW-1:0] pix_addr;
    logic [PW-1:0] pix_data;
    logic          pix_we, frame_done, frame_ok, overflow;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic          done_q[$];
    logic [EW-1:0] mon_e;
    logic          mon_ok;

    logic       pat_mode;
    logic [7:0] cb0, cb1;

    camera_capture_param #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .PIX_W(PW), .SKIP_FRAMES(SK)
    ) dut (
        .pclk(pclk), .rst(rst), .enable(enable), .vsync(vsync), .href(href),
        .data(data), .fmt(fmt), .decim(decim), .pix_addr(pix_addr),
        .pix_data(pix_data), .pix_we(pix_we), .frame_done(frame_done),
        .frame_ok(frame_ok), .overflow(overflow)
    );

    // Clock / reset
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge pclk) begin
        if (!rst) begin
            if (pix_we) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr=%0d data=0x%0h, required no write",
                             pix_addr, pix_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr_data", {11'd0, pix_addr, pix_data}, {11'd0, mon_e});
                end
            end
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame_done: got frame_done=1, required 0");
                end else begin
                    mon_ok = done_q.pop_front();
                    check("frame_ok_at_done", {31'd0, frame_ok}, {31'd0, mon_ok});
                end
            end
        end
    end

    // Driver tasks
    function automatic logic [7:0] pat_byte(input int l, input int b);
        logic [3:0] ln;
        logic [3:0] cn;
        ln = 4'(l);
        cn = 4'(b / 2);
        if (!pat_mode) return (b % 2 == 0) ? cb0 : cb1;
        return (b % 2 == 0) ? {ln, cn} : {4'hC, cn};
    endfunction

    function automatic logic [15:0] pat_565(input int l, input int c);
        return {4'(l), 4'(c), 4'hC, 4'(c)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic frame_begin();
        vsync = 1'b1;
        href  = 1'b0;
        tick(4);
        vsync = 1'b0;
        tick(3);
    endtask

    task automatic frame_end();
        vsync = 1'b1;
        tick(4);
    endtask

    task automatic send_line(input int l, input int nbytes);
        for (int b = 0; b < nbytes; b++) begin
            href = 1'b1;
            data = pat_byte(l, b);
            tick(1);
        end
        href = 1'b0;
        data = 8'h00;
        tick(3);
    endtask

    task automatic send_full_frame();
        frame_begin();
        for (int l = 0; l < V; l++) send_line(l, 2 * H);
        frame_end();
    endtask

    task automatic push_w(input int a, input logic [15:0] d);
        exp_q.push_back({AW'(a), d});
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
        fmt = 2'd0; decim = 1'b0; pat_mode = 1'b0; cb0 = 8'h00; cb1 = 8'h00;
        tick(2);
        check("reset_pix_we", {31'd0, pix_we}, 32'd0);
        check("reset_pix_addr", {27'd0, pix_addr}, 32'd0);
        check("reset_pix_data", {16'd0, pix_data}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        check("reset_frame_ok", {31'd0, frame_ok}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Skip: two frames dropped, third captured in RGB444
        enable = 1'b1; fmt = 2'd0; cb0 = 8'hA5; cb1 = 8'h3C;
        tick(2);
        send_full_frame();
        send_full_frame();
        for (int a = 0; a < H * V; a++) push_w(a, 16'h053C);
        done_q.push_back(1'b1);
        send_full_frame();
        check("skip_overflow", {31'd0, overflow}, 32'd0);

        // Formats, with a mid-frame fmt change that must not take effect
        fmt = 2'd1; cb0 = 8'hF8; cb1 = 8'h1F;
        for (int a = 0; a < H * V; a++) push_w(a, 16'hF81F);
        done_q.push_back(1'b1);
        send_full_frame();
        fmt = 2'd2;
        for (int a = 0; a < H * V; a++) push_w(a, 16'h00F8);
        done_q.push_back(1'b1);
        frame_begin();
        send_line(0, 16);
        send_line(1, 16);
        fmt = 2'd1;
        send_line(2, 16);
        send_line(3, 16);
        frame_end();

        // Decimation: even columns of lines 0 and 2, dense addresses
        decim = 1'b1; pat_mode = 1'b1;
        begin
            int a;
            a = 0;
            for (int l = 0; l < V; l += 2)
                for (int c = 0; c < H; c += 2) begin
                    push_w(a, pat_565(l, c));
                    a++;
                end
        end
        done_q.push_back(1'b1);
        send_full_frame();
        decim = 1'b0;

        // Bounds: 10-pixel line and a fifth line
        for (int l = 0; l < V; l++)
            for (int c = 0; c < H; c++) push_w(l * H + c, pat_565(l, c));
        done_q.push_back(1'b0);
        frame_begin();
        send_line(0, 16);
        send_line(1, 20);
        send_line(2, 16);
        send_line(3, 16);
        send_line(4, 16);
        frame_end();
        check("bounds_overflow_set", {31'd0, overflow}, 32'd1);
        check("bounds_frame_ok", {31'd0, frame_ok}, 32'd0);

        // Odd byte count on line 0; next frame start clears overflow
        for (int c = 0; c < 3; c++) push_w(c, pat_565(0, c));
        for (int l = 1; l < V; l++)
            for (int c = 0; c < H; c++) push_w(3 + (l - 1) * H + c, pat_565(l, c));
        done_q.push_back(1'b1);
        frame_begin();
        check("odd_overflow_cleared", {31'd0, overflow}, 32'd0);
        check("odd_frame_ok_held", {31'd0, frame_ok}, 32'd0);
        send_line(0, 7);
        for (int l = 1; l < V; l++) send_line(l, 16);
        frame_end();
        check("odd_frame_ok", {31'd0, frame_ok}, 32'd1);

        // Async reset at pixel 5 of line 0
        for (int c = 0; c < 4; c++) push_w(c, pat_565(0, c));
        frame_begin();
        for (int b = 0; b < 10; b++) begin
            href = 1'b1;
            data = pat_byte(0, b);
            tick(1);
        end
        rst = 1'b1;
        #1;
        check("abort_pix_we", {31'd0, pix_we}, 32'd0);
        check("abort_pix_addr", {27'd0, pix_addr}, 32'd0);
        check("abort_pix_data", {16'd0, pix_data}, 32'd0);
        check("abort_frame_done", {31'd0, frame_done}, 32'd0);
        check("abort_frame_ok", {31'd0, frame_ok}, 32'd0);
        check("abort_overflow", {31'd0, overflow}, 32'd0);
        href = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        frame_end();

        // Skip sequence restarts from zero, then a Y8 capture
        fmt = 2'd2; pat_mode = 1'b0; cb0 = 8'h3C; cb1 = 8'h99;
        send_full_frame();
        send_full_frame();
        for (int a = 0; a < H * V; a++) push_w(a, 16'h003C);
        done_q.push_back(1'b1);
        send_full_frame();
        tick(4);

        check("writes_drained", exp_q.size(), 32'd0);
        check("frames_drained", done_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/camera_capture_param.md
Name: camera_capture_param

Overview:
- Parametrised successor to the OV7670 frame-capture block.
- Sits between the camera pins and the frame-buffer write port: assembles byte pairs into pixels in a run-time selectable format, with optional 2x decimation (QVGA from VGA).
- Produces a write strobe, a linear address and a per-frame status.
- Skips a configurable number of frames after enable; bounds-checks line and pixel counts.

Parameters:
- H_ACTIVE, 640, pixels per line delivered by the camera.
- V_ACTIVE, 480, lines per frame.
- ADDR_W, 19, width of pix_addr; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- PIX_W, 16, output pixel width; minimum 16.
- SKIP_FRAMES, 2, complete frames discarded after enable rises or after reset; 0 is legal.

Ports:
- pclk  in  1  camera pixel clock; the only clock. All logic is on posedge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable. Low forces IDLE_OFF at the next edge.
- vsync  in  1  camera vertical sync, high during blanking.
- href  in  1  camera line valid.
- data  in  8  camera byte.
- fmt  in  2  0=RGB444, 1=RGB565, 2=Y8 (YUV422 luma), 3=reserved (treated as 0).
- decim  in  1  1 = keep even pixels of even lines only.
- pix_addr  out  ADDR_W  write address.
- pix_data  out  PIX_W  write data.
- pix_we  out  1  one-cycle write strobe.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_ok  out  1  status of last frame; valid from the frame_done pulse.
- overflow  out  1  sticky: pixels or lines exceeded limits; cleared by the next accepted frame start or by rst.

Behaviour:
- Reset: all outputs 0, state IDLE_OFF, skip counter 0, byte phase 0.
- Input sampling:
  - vsync, href and data are registered once on posedge (stage s1).
  - vsync_q is delayed one further stage (s2).
  - vs_fall = s2 & ~s1; vs_rise = ~s2 & s1.
- State machine:
  - IDLE_OFF -> SKIP when enable.
  - SKIP: count vs_fall events. After SKIP_FRAMES falls, move to WAIT. With SKIP_FRAMES=0, move to WAIT immediately.
  - WAIT: on vs_fall, go to CAPTURE. On the same edge: latch fmt and decim; clear the address, line, column and byte phase; clear overflow.
  - CAPTURE: on vs_rise, pulse frame_done and go to WAIT. There is no re-skip between frames.
  - From any state, enable low -> IDLE_OFF. If this happens mid-frame, no frame_done is issued.
- Byte assembly in CAPTURE, while s1 href is high:
  - Phase 0 stores byte0. Phase 1 forms the pixel and toggles phase.
  - A falling edge of s1 href: resets phase to 0 (a dangling odd byte is discarded), increments line, clears column.
- Format mapping (upper bits zero-filled to PIX_W):
  - RGB444: {byte0[3:0], byte1}.
  - RGB565: {byte0, byte1}.
  - Y8: {byte0}; byte1 (U/V) is ignored.
- Write rules:
  - pix_we is asserted the cycle after the phase-1 byte is sampled, so there is 2 cycles of latency from the data pin.
  - pix_data and pix_addr are valid with pix_we.
  - pix_addr increments after each write; the first write of a frame is at address 0.
  - decim=1: write only when column[0]==0 and line[0]==0. The address stays dense, giving (H_ACTIVE/2)*(V_ACTIVE/2) addresses.
  - Column increments per assembled pixel regardless of decimation.
- Bounds:
  - A pixel with column >= H_ACTIVE, or an href with line >= V_ACTIVE: no write, and overflow is set.
  - pix_addr never wraps or exceeds the last legal address.
- Frame status: frame_ok = (line count == V_ACTIVE) & ~overflow, evaluated at vs_rise and held until the next frame_done.
- Simultaneous events:
  - vs_rise with a pending phase-1 pixel: the pixel is written first; frame_done appears in the same cycle as that pix_we.
  - vs_fall while in CAPTURE without a preceding vs_rise (missed frame end): restart the frame with frame_done=0 and frame_ok unchanged.

Test Plan:
- Skip count: reset, SKIP_FRAMES=2, three 4x2 frames in RGB444 -> only the 3rd frame writes. 8 pix_we at addresses 0..7; byte pair 0xA5,0x3C gives pix_data 0x053C; frame_done once; frame_ok=1.
- Format: fmt=1 then fmt=2 on consecutive frames with bytes 0xF8,0x1F -> 0xF81F, then 0x00F8. Also toggle fmt mid-frame -> no change until the next vs_fall.
- Decimation: decim=1 on an 8x4 frame -> 8 writes at addresses 0..7, taken from even columns of lines 0 and 2 only.
- Bounds: a line with 10 pixels when H_ACTIVE=8, and 5 lines when V_ACTIVE=4 -> no address beyond 31; overflow=1; frame_ok=0. The next frame start clears overflow.
- Odd byte: href drops after 7 bytes -> 3 writes; the next line starts at phase 0 with correct pixels.
- Async reset mid-capture: assert rst at pixel 5 -> all outputs 0 immediately. After release, the skip sequence restarts from 0 and no frame_done is issued for the aborted frame.
